// File: rtl/cmd_reply_gen.sv
// cmd_reply_gen: captures an echoed command header burst and an optional
// reply payload burst, then emits one contiguous reply frame:
//   header (first byte | 0x80), len[15:8], len[7:0], payload, XOR checksum.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   reply_con/_en     header byte stream from the command parser
//   ack_data/_en      payload byte stream (readback data)
//   tx_ready          downstream can take a whole frame (sampled in WAIT_TX only)
//   con_dout/_en      reply frame byte stream (0x00 when not valid)
//   busy              high whenever the FSM is not idle
//   pl_ovf            one-cycle pulse per dropped payload byte
module cmd_reply_gen #(
  parameter int TIMEOUT = 1023,
  parameter int PL_MAX  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reply_con,
  input  logic       reply_con_en,
  input  logic [7:0] ack_data,
  input  logic       ack_data_en,
  input  logic       tx_ready,
  output logic [7:0] con_dout,
  output logic       con_dout_en,
  output logic       busy,
  output logic       pl_ovf
);
  localparam int          AW      = (PL_MAX > 1) ? $clog2(PL_MAX) : 1;
  localparam logic [9:0]  TO_LAST = 10'(TIMEOUT - 1);
  localparam logic [15:0] PL_LIM  = 16'(PL_MAX);

  typedef enum logic [3:0] {
    IDLE, HDR_CAP, WAIT_PL, PL_CAP, WAIT_TX,
    SEND_HDR, SEND_LEN, SEND_PL, SEND_CHK
  } state_t;

  state_t      state;
  logic [7:0]  hdr [8];
  logic [7:0]  mem [PL_MAX];
  logic [3:0]  hdr_len;
  logic [15:0] pl_len;
  logic [15:0] idx;
  logic [7:0]  chk;
  logic [9:0]  tcnt;

  assign busy = (state != IDLE);

  // Header buffer: byte 0 on burst start, then up to 7 more; extras dropped.
  always_ff @(posedge clk) begin
    if (state == IDLE && reply_con_en)
      hdr[0] <= reply_con;
    else if (state == HDR_CAP && reply_con_en && hdr_len < 4'd8)
      hdr[hdr_len[2:0]] <= reply_con;
  end

  // Payload buffer: pl_len doubles as the write pointer (0 in WAIT_PL).
  always_ff @(posedge clk) begin
    if (ack_data_en && (state == WAIT_PL || (state == PL_CAP && pl_len < PL_LIM)))
      mem[pl_len[AW-1:0]] <= ack_data;
  end

  // In the SEND_* states the state names the class of byte currently on
  // con_dout; each edge picks the next byte so the first header byte lands
  // one cycle after tx_ready is seen and the frame has no gaps. chk always
  // holds the XOR of every byte emitted so far.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hdr_len     <= '0;
      pl_len      <= '0;
      idx         <= '0;
      chk         <= '0;
      tcnt        <= '0;
      con_dout    <= '0;
      con_dout_en <= 1'b0;
      pl_ovf      <= 1'b0;
    end else begin
      pl_ovf <= 1'b0;
      case (state)
        IDLE: if (reply_con_en) begin
          hdr_len <= 4'd1;
          pl_len  <= '0;
          state   <= HDR_CAP;
        end
        HDR_CAP: if (reply_con_en) begin
          if (hdr_len < 4'd8) hdr_len <= hdr_len + 4'd1;
        end else begin
          tcnt  <= '0;
          state <= WAIT_PL;
        end
        // Payload wins over a simultaneous header byte. The counter stops at
        // TO_LAST, so it can never wrap.
        WAIT_PL: if (ack_data_en) begin
          pl_len <= 16'd1;
          state  <= PL_CAP;
        end else if (tcnt >= TO_LAST) begin
          pl_len <= '0;
          state  <= WAIT_TX;
        end else begin
          tcnt <= tcnt + 10'd1;
        end
        PL_CAP: if (ack_data_en) begin
          if (pl_len < PL_LIM) pl_len <= pl_len + 16'd1;
          else                 pl_ovf <= 1'b1;
        end else begin
          state <= WAIT_TX;
        end
        WAIT_TX: if (tx_ready) begin
          con_dout    <= hdr[0] | 8'h80;
          con_dout_en <= 1'b1;
          chk         <= hdr[0] | 8'h80;
          idx         <= 16'd1;
          state       <= SEND_HDR;
        end
        SEND_HDR: if (idx < 16'(hdr_len)) begin
          con_dout <= hdr[idx[2:0]];
          chk      <= chk ^ hdr[idx[2:0]];
          idx      <= idx + 16'd1;
        end else begin
          con_dout <= pl_len[15:8];
          chk      <= chk ^ pl_len[15:8];
          idx      <= '0;
          state    <= SEND_LEN;
        end
        // idx 0: high length byte showing; idx 1: low length byte showing.
        SEND_LEN: if (idx == 16'd0) begin
          con_dout <= pl_len[7:0];
          chk      <= chk ^ pl_len[7:0];
          idx      <= 16'd1;
        end else if (pl_len != 16'd0) begin
          con_dout <= mem[{AW{1'b0}}];
          chk      <= chk ^ mem[{AW{1'b0}}];
          state    <= SEND_PL;
        end else begin
          con_dout <= chk;
          state    <= SEND_CHK;
        end
        SEND_PL: if (idx < pl_len) begin
          con_dout <= mem[idx[AW-1:0]];
          chk      <= chk ^ mem[idx[AW-1:0]];
          idx      <= idx + 16'd1;
        end else begin
          con_dout <= chk;
          state    <= SEND_CHK;
        end
        SEND_CHK: begin
          con_dout    <= '0;
          con_dout_en <= 1'b0;
          hdr_len     <= '0;
          pl_len      <= '0;
          idx         <= '0;
          chk         <= '0;
          tcnt        <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cmd_reply_gen.md
CMD_REPLY_GEN -- requirements
Module: cmd_reply_gen

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, cycles to wait for a payload after the header burst ends.
REQ-002 SHALL have parameter PL_MAX, default 256, maximum payload bytes buffered.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 reply_con  input  8  echoed command header byte from the command parser.
REQ-006 reply_con_en  input  1  header byte valid; one contiguous burst per command.
REQ-007 ack_data  input  8  reply payload byte (SI/rate readback).
REQ-008 ack_data_en  input  1  payload byte valid; one contiguous burst per reply.
REQ-009 tx_ready  input  1  downstream can accept a complete frame.
REQ-010 con_dout  output  8  reply frame byte.
REQ-011 con_dout_en  output  1  reply byte valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 pl_ovf  output  1  one-cycle pulse when a payload byte beyond PL_MAX is dropped.

Function
REQ-014 SHALL use states IDLE, HDR_CAP, WAIT_PL, PL_CAP, WAIT_TX, SEND_HDR, SEND_LEN, SEND_PL, SEND_CHK.
REQ-015 IDLE: reply_con_en=1 SHALL store the byte as header[0], set hdr_len=1, and go to HDR_CAP.
REQ-016 HDR_CAP: each reply_con_en=1 cycle SHALL store the next byte while hdr_len<8; bytes 9+ are discarded; reply_con_en=0 goes to WAIT_PL.
REQ-017 WAIT_PL: ack_data_en=1 SHALL store the byte, set pl_len=1, and go to PL_CAP.
REQ-018 WAIT_PL: after TIMEOUT cycles with no ack_data_en, SHALL go to WAIT_TX with pl_len=0.
REQ-019 PL_CAP: each ack_data_en=1 cycle SHALL store the byte while pl_len<PL_MAX; otherwise the byte is dropped and pl_ovf pulses; ack_data_en=0 goes to WAIT_TX.
REQ-020 WAIT_TX: tx_ready=1 SHALL go to SEND_HDR; tx_ready is sampled only in this state.
REQ-021 Frame order SHALL be: hdr_len header bytes, pl_len[15:8], pl_len[7:0], pl_len payload bytes, then 1 checksum byte.
REQ-022 The first header byte SHALL be emitted as header[0] | 8'h80; all other header bytes are emitted unmodified.
REQ-023 Checksum SHALL be the XOR of every frame byte emitted before it, including the modified first byte and both length bytes.
REQ-024 con_dout_en SHALL be high every cycle from the first header byte through the checksum, with no gaps, regardless of tx_ready.
REQ-025 Frame length SHALL equal hdr_len+2+pl_len+1 cycles.
REQ-026 The first byte SHALL appear on con_dout on the cycle after WAIT_TX samples tx_ready=1.
REQ-027 After SEND_CHK, SHALL return to IDLE and clear hdr_len, pl_len and the checksum accumulator.
REQ-028 When con_dout_en=0, con_dout SHALL be 8'h00.
REQ-029 reply_con_en outside IDLE/HDR_CAP SHALL be ignored.
REQ-030 ack_data_en outside WAIT_PL/PL_CAP SHALL be ignored.
REQ-031 If reply_con_en and ack_data_en are both high in WAIT_PL, the payload byte SHALL be accepted and the header byte ignored.
REQ-032 Payload SHALL be buffered in a PL_MAX x 8 memory; the write pointer resets to 0 for each frame and never wraps.
REQ-033 The timeout counter SHALL be 10 bits wide and saturate; it clears on entry to WAIT_PL.

Reset
REQ-034 rst SHALL force state IDLE, con_dout=0, con_dout_en=0, busy=0, pl_ovf=0, and hdr_len=pl_len=checksum=timeout counter=0.
REQ-035 rst mid-frame SHALL abort the frame immediately with no further con_dout_en; buffer contents need not be cleared.
REQ-036 All outputs SHALL be valid on the first cycle after rst deasserts.

Verification
REQ-037 Header 04 01 00 00 00 00 00 08, no payload, tx_ready=1 -> after TIMEOUT: 84 01 00 00 00 00 00 08 00 00 8D; 11 contiguous cycles.
REQ-038 Same header then payload AA 55 -> 84 01 00 00 00 00 00 08 00 02 AA 55 70.
REQ-039 Payload of 300 bytes -> length field 01 00; exactly 256 payload bytes emitted; pl_ovf pulses 44 times.
REQ-040 tx_ready held 0 for 50 cycles in WAIT_TX -> con_dout_en stays 0 and busy=1; first byte appears on the cycle after tx_ready is sampled 1.
REQ-041 Header burst of 10 bytes -> only the first 8 are framed; the header burst during SEND_PL is ignored and causes no corruption.
REQ-042 rst asserted during SEND_PL -> con_dout_en=0 on the next cycle; a new header after reset produces a correct frame.
